// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking gate scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PULSE_HI = 2'd1,
    PULSE_LO = 2'd2,
    SETTLE   = 2'd3
  } state_t;

  typedef enum logic {
    OP_ENTRY = 1'b0,
    OP_EXIT  = 1'b1
  } op_t;

  localparam int DEF_NUM_GATES = 4;
  localparam int DEF_PULSE_HIGH = 2;
  localparam int DEF_PULSE_LOW  = 2;
  localparam int DEF_CNT_W      = 10;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick of one requester, searching upward from ptr and wrapping.
// Latency: combinational, same cycle.
// Backpressure: none; caller advances ptr after consuming the pick.
// Ports: req  - request vector
//        ptr  - index where the search starts
//        gnt  - one-hot pick; index - its binary index; valid - any request seen
module rr_arbiter
  import parking_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] index,
  output logic          valid
);

  logic [IW-1:0] w_cand;

  always_comb begin
    gnt    = '0;
    index  = '0;
    valid  = 1'b0;
    w_cand = '0;
    for (int i = 0; i < N; i++) begin
      w_cand = IW'((int'(ptr) + i) % N);
      if (!valid && req[w_cand]) begin
        valid       = 1'b1;
        index       = w_cand;
        gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/parking_gate_scheduler.sv
// Serialises per-gate entry/exit requests into single car_entered/car_exited strobes.
// Latency: grant/deny in the same cycle a request is seen in IDLE; strobe rises next cycle; one event per PULSE_HIGH+PULSE_LOW+2 cycles.
// Backpressure: requests are held by the gate until grant or deny; busy marks the event window.
// Ports: clk/rst (sync, active-high); entry_*/exit_* per-gate level requests and class;
//        vacancy flags and occupancy counts from ParkingSystem; car_* strobes and class
//        qualifiers to ParkingSystem; one-hot grant/deny pulses back to the gates; busy.
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int NUM_GATES  = DEF_NUM_GATES,
  parameter int PULSE_HIGH = DEF_PULSE_HIGH,
  parameter int PULSE_LOW  = DEF_PULSE_LOW,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_GATES-1:0] entry_req,
  input  logic [NUM_GATES-1:0] entry_is_uni,
  input  logic [NUM_GATES-1:0] exit_req,
  input  logic [NUM_GATES-1:0] exit_is_uni,
  input  logic                 uni_is_vacated_space,
  input  logic                 free_is_vacated_space,
  input  logic [CNT_W-1:0]     uni_parked_car,
  input  logic [CNT_W-1:0]     free_parked_car,
  output logic                 car_entered,
  output logic                 is_uni_car_entered,
  output logic                 car_exited,
  output logic                 is_uni_car_exited,
  output logic [NUM_GATES-1:0] entry_grant,
  output logic [NUM_GATES-1:0] entry_deny,
  output logic [NUM_GATES-1:0] exit_grant,
  output logic [NUM_GATES-1:0] exit_deny,
  output logic                 busy
);

  localparam int GW = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
  localparam int TW = 8;

  state_t          r_state, w_next;
  op_t             r_op;
  logic [TW-1:0]   r_tmr;
  logic [GW-1:0]   r_eptr, r_xptr;
  logic            r_uni_entered, r_uni_exited;

  logic [NUM_GATES-1:0] w_e_gnt, w_x_gnt;
  logic [GW-1:0]        w_e_idx, w_x_idx;
  logic                 w_e_vld, w_x_vld;
  logic                 w_idle, w_e_cls, w_x_cls, w_e_ok, w_x_ok;
  logic                 w_serve_e, w_serve_x, w_fire_e, w_fire_x;

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] g);
    if (int'(g) >= NUM_GATES - 1) return '0;
    return g + 1'b1;
  endfunction

  rr_arbiter #(.N(NUM_GATES), .IW(GW)) u_entry_arb (
    .req(entry_req), .ptr(r_eptr), .gnt(w_e_gnt), .index(w_e_idx), .valid(w_e_vld)
  );

  rr_arbiter #(.N(NUM_GATES), .IW(GW)) u_exit_arb (
    .req(exit_req), .ptr(r_xptr), .gnt(w_x_gnt), .index(w_x_idx), .valid(w_x_vld)
  );

  // Decisions only in IDLE and never while reset is asserted, so the
  // reset cycle itself shows no grant/deny.
  assign w_idle    = (r_state == IDLE) && !rst;
  assign w_x_cls   = exit_is_uni[w_x_idx];
  assign w_x_ok    = w_x_cls ? (uni_parked_car != '0) : (free_parked_car != '0);
  assign w_e_cls   = entry_is_uni[w_e_idx];
  assign w_e_ok    = w_e_cls ? uni_is_vacated_space : free_is_vacated_space;
  // Exits win so a freed space is visible before the next entry is judged.
  assign w_serve_x = w_idle && w_x_vld;
  assign w_serve_e = w_idle && !w_x_vld && w_e_vld;
  assign w_fire_x  = w_serve_x && w_x_ok;
  assign w_fire_e  = w_serve_e && w_e_ok;

  always_comb begin
    w_next      = r_state;
    entry_grant = '0;
    entry_deny  = '0;
    exit_grant  = '0;
    exit_deny   = '0;
    case (r_state)
      IDLE: begin
        if (w_serve_x) begin
          if (w_x_ok) begin
            exit_grant = w_x_gnt;
            w_next     = PULSE_HI;
          end else begin
            exit_deny = w_x_gnt;
          end
        end else if (w_serve_e) begin
          if (w_e_ok) begin
            entry_grant = w_e_gnt;
            w_next      = PULSE_HI;
          end else begin
            entry_deny = w_e_gnt;
          end
        end
      end
      PULSE_HI: if (r_tmr == TW'(PULSE_HIGH - 1)) w_next = PULSE_LO;
      PULSE_LO: if (r_tmr == TW'(PULSE_LOW - 1))  w_next = SETTLE;
      SETTLE:   w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_op          <= OP_ENTRY;
      r_tmr         <= '0;
      r_eptr        <= '0;
      r_xptr        <= '0;
      r_uni_entered <= 1'b0;
      r_uni_exited  <= 1'b0;
    end else begin
      r_state <= w_next;
      // Timer counts cycles spent in the current timed state.
      r_tmr   <= ((w_next != r_state) || (r_state == IDLE)) ? '0 : r_tmr + 1'b1;
      if (w_fire_x) begin
        r_op         <= OP_EXIT;
        r_uni_exited <= w_x_cls;
      end
      if (w_fire_e) begin
        r_op          <= OP_ENTRY;
        r_uni_entered <= w_e_cls;
      end
      if (w_serve_x) r_xptr <= wrap_inc(w_x_idx);
      if (w_serve_e) r_eptr <= wrap_inc(w_e_idx);
    end
  end

  assign car_entered        = (r_state == PULSE_HI) && (r_op == OP_ENTRY);
  assign car_exited         = (r_state == PULSE_HI) && (r_op == OP_EXIT);
  // Qualifier shows the new class already in the grant cycle, then holds.
  assign is_uni_car_entered = w_fire_e ? w_e_cls : r_uni_entered;
  assign is_uni_car_exited  = w_fire_x ? w_x_cls : r_uni_exited;
  assign busy               = (r_state != IDLE) || w_fire_e || w_fire_x;

endmodule

// File: doc/parking_gate_scheduler.md
Name: parking_gate_scheduler

Overview:
- Front-end controller for the ParkingSystem counter block.
- Collects entry and exit requests from NUM_GATES physical gates and serialises them into single, well-formed car_entered/car_exited pulses with a stable uni/free qualifier.
- Uses the block's vacancy flags and occupancy counts to grant or deny each request.
- Sits between the gate sensors/barriers and ParkingSystem; ParkingSystem counts on the rising edge of car_entered/car_exited.

Parameters:
- NUM_GATES, 4, number of gates; each gate has an entry and an exit lane.
- PULSE_HIGH, 2, cycles the event strobe is held high.
- PULSE_LOW, 2, minimum low cycles after the strobe before the next event.
- CNT_W, 10, width of the occupancy inputs (matches ParkingSystem).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- entry_req  in  NUM_GATES  level request per gate; held until entry_grant or entry_deny
- entry_is_uni  in  NUM_GATES  car class per entry lane (1 = university)
- exit_req  in  NUM_GATES  level request per gate; held until exit_grant or exit_deny
- exit_is_uni  in  NUM_GATES  car class per exit lane
- uni_is_vacated_space  in  1  from ParkingSystem
- free_is_vacated_space  in  1  from ParkingSystem
- uni_parked_car  in  CNT_W  from ParkingSystem
- free_parked_car  in  CNT_W  from ParkingSystem
- car_entered  out  1  entry strobe to ParkingSystem
- is_uni_car_entered  out  1  entry class qualifier
- car_exited  out  1  exit strobe to ParkingSystem
- is_uni_car_exited  out  1  exit class qualifier
- entry_grant  out  NUM_GATES  one-hot, one-cycle; open barrier
- entry_deny  out  NUM_GATES  one-hot, one-cycle; show "full"
- exit_grant  out  NUM_GATES  one-hot, one-cycle
- exit_deny  out  NUM_GATES  one-hot, one-cycle; count underflow guard
- busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Clocking and reset: single clock domain; all registers update on posedge clk.
- Reset values (rst = 1): all outputs 0, FSM = IDLE, both round-robin pointers = 0.
- Reset mid-pulse: strobes drop low the next cycle; the in-flight event is abandoned with no re-issue.
- FSM states: IDLE, PULSE_HI, PULSE_LO, SETTLE.
- IDLE, any exit_req pending:
  - Select an exit lane by exit round-robin pointer; exits take priority over entries.
  - Class count (uni_parked_car or free_parked_car per exit_is_uni) != 0: assert exit_grant[g] for 1 cycle, latch class into is_uni_car_exited, go to PULSE_HI.
  - Class count == 0: assert exit_deny[g] for 1 cycle, stay in IDLE.
- IDLE, only entry_req pending:
  - Select an entry lane by entry pointer.
  - Uni car needs uni_is_vacated_space = 1; free car needs free_is_vacated_space = 1.
  - Space available: entry_grant[g] for 1 cycle, latch class into is_uni_car_entered, go to PULSE_HI.
  - No space: entry_deny[g] for 1 cycle, stay in IDLE.
- Pointer rule: after any grant or deny, the relevant pointer becomes (g+1) mod NUM_GATES. The search starts at the pointer and wraps.
- PULSE_HI: the selected strobe is high for exactly PULSE_HIGH cycles; the strobe's rising edge is the cycle after the grant. Then go to PULSE_LO.
- PULSE_LO: both strobes low for PULSE_LOW cycles, then go to SETTLE.
- SETTLE: 1 cycle so ParkingSystem outputs reflect the event, then go to IDLE.
- Qualifier hold: is_uni_car_entered/is_uni_car_exited stay stable from the grant cycle through SETTLE. They keep their last value in IDLE.
- Event spacing: one event per PULSE_HIGH+PULSE_LOW+2 cycles (6 at default). Requests are never lost while held.
- Simultaneous entry and exit on the same gate: exit served first; the entry is re-evaluated afterwards with fresh vacancy flags.
- Invariants: never both strobes high; grant/deny never asserted outside IDLE; at most one bit set across all four grant/deny vectors per cycle.
- Request dropped before service: ignored, no grant or deny.

Decomposition:
- parking_pkg contains:
  - state enum {IDLE, PULSE_HI, PULSE_LO, SETTLE}
  - op enum {OP_ENTRY, OP_EXIT}
  - default PULSE_HIGH/PULSE_LOW constants
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; outputs one-hot gnt, index, valid. Instantiated twice, once for entry and once for exit.

Test Plan:
- Reset, then entry_req[0]=1 uni with uni_is_vacated_space=1 -> entry_grant=0001 next cycle; car_entered high 2 cycles; is_uni_car_entered=1; busy for 6 cycles.
- entry_req=1111 all free class, space available -> grants in order 0,1,2,3, one every 6 cycles; 4 car_entered rising edges.
- uni_is_vacated_space=0, uni entry request on gate 2 -> entry_deny=0100 for 1 cycle, no strobe; a free entry on gate 3 in the same window is granted afterwards.
- exit_req[1] uni with uni_parked_car=0 -> exit_deny=0010, car_exited stays 0; with uni_parked_car=5 -> exit_grant=0010 and a 2-cycle car_exited pulse.
- entry_req[0] and exit_req[0] asserted in the same cycle -> exit served first; entry granted 6 cycles later.
- rst=1 in the second PULSE_HI cycle -> car_entered=0 next cycle, busy=0, pointers=0; a held request is re-granted starting from gate 0.
